// File: rtl/binary_target_locator_if.sv
// Pixel stream bundle for the binarized mask path.
// A master drives the stream and a slave consumes it.
//   vsync : frame sync, active high; its rising edge marks a frame start
//   href  : line valid
//   clken : pixel valid
//   data  : 8-bit mask pixel (8'h00 = target, anything else = background)
interface binary_target_locator_if;
    logic       vsync;
    logic       href;
    logic       clken;
    logic [7:0] data;

    modport master (output vsync, href, clken, data);
    modport slave  (input  vsync, href, clken, data);
endinterface

// File: rtl/binary_target_locator.sv
// Binary target locator.
// Tracks the bounding box and pixel count of target pixels (8'h00) over
// each frame of a binarized stream and publishes them at the next frame
// start. The stream is re-emitted one cycle later, with the last published
// box drawn onto it.
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   bin   (slave)   : incoming mask stream
//   ovl   (master)  : outgoing stream with box overlay, 1-cycle latency
//   o_box_valid     : one-cycle pulse when the result registers update
//   o_found         : last completed frame had at least MIN_PIX targets
//   o_x_min/o_x_max : published box horizontal extent
//   o_y_min/o_y_max : published box vertical extent
//   o_pix_cnt       : target count of last frame, saturating
module binary_target_locator #(
    parameter int         IMG_W   = 640,
    parameter int         IMG_H   = 480,
    parameter int         MIN_PIX = 64,
    parameter logic [7:0] BOX_VAL = 8'h80
) (
    input  logic                           clk,
    input  logic                           rst_n,
    binary_target_locator_if.slave         bin,
    binary_target_locator_if.master        ovl,
    output logic                           o_box_valid,
    output logic                           o_found,
    output logic [10:0]                    o_x_min,
    output logic [10:0]                    o_x_max,
    output logic [9:0]                     o_y_min,
    output logic [9:0]                     o_y_max,
    output logic [19:0]                    o_pix_cnt
);

    localparam logic [10:0] X_LAST  = 11'(IMG_W - 1);
    localparam logic [9:0]  Y_LAST  = 10'(IMG_H - 1);
    localparam logic [19:0] CNT_MAX = 20'hFFFFF;
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIX);

    typedef enum logic [1:0] {IDLE, ACTIVE, PUBLISH} state_t;

    state_t      state, state_nxt;
    logic        vsync_d, href_d;
    logic        vs_rise, href_fall;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic        x_over, y_over;
    logic        in_range, pix_event;
    logic        acc_clear, publish, acc_found;
    logic [10:0] acc_x_min, acc_x_max, x_min_nxt, x_max_nxt;
    logic [9:0]  acc_y_min, acc_y_max, y_min_nxt, y_max_nxt;
    logic [19:0] acc_cnt, cnt_nxt;
    logic        on_vline, on_hline, draw;

    assign vs_rise   = bin.vsync & ~vsync_d;
    assign href_fall = ~bin.href & href_d;

    // Delayed copies of the syncs for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= bin.vsync;
            href_d  <= bin.href;
        end
    end

    // Column counter. x_cnt holds the column of the pixel currently on the
    // bus; once the last column has been consumed, x_over flags the rest of
    // the line as out of range so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt  <= '0;
            x_over <= 1'b0;
        end else if (!bin.href) begin
            x_cnt  <= '0;
            x_over <= 1'b0;
        end else if (bin.clken) begin
            if (x_cnt == X_LAST) x_over <= 1'b1;
            else                 x_cnt  <= x_cnt + 11'd1;
        end
    end

    // Line counter, same saturation idea: lines after the last are ignored
    // until the next frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_cnt  <= '0;
            y_over <= 1'b0;
        end else if (vs_rise) begin
            y_cnt  <= '0;
            y_over <= 1'b0;
        end else if (href_fall) begin
            if (y_cnt == Y_LAST) y_over <= 1'b1;
            else                 y_cnt  <= y_cnt + 10'd1;
        end
    end

    assign in_range  = ~x_over & ~y_over;
    // A pixel sharing a cycle with the frame-start edge belongs to neither
    // frame and is dropped.
    assign pix_event = bin.href & bin.clken & (bin.data == 8'h00) & in_range
                     & ~vs_rise & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // IDLE swallows the partial frame seen after reset; PUBLISH is a single
    // cycle that both reports the finished frame and starts the next one.
    always_comb begin
        state_nxt = state;
        acc_clear = 1'b0;
        publish   = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nxt = ACTIVE;
                    acc_clear = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) state_nxt = PUBLISH;
            end
            PUBLISH: begin
                publish   = 1'b1;
                acc_clear = 1'b1;
                state_nxt = ACTIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear-then-update: a pixel arriving in the clearing cycle is folded
    // into the fresh values rather than lost.
    always_comb begin
        x_min_nxt = acc_clear ? X_LAST : acc_x_min;
        x_max_nxt = acc_clear ? 11'd0  : acc_x_max;
        y_min_nxt = acc_clear ? Y_LAST : acc_y_min;
        y_max_nxt = acc_clear ? 10'd0  : acc_y_max;
        cnt_nxt   = acc_clear ? 20'd0  : acc_cnt;
        if (pix_event) begin
            if (x_cnt < x_min_nxt) x_min_nxt = x_cnt;
            if (x_cnt > x_max_nxt) x_max_nxt = x_cnt;
            if (y_cnt < y_min_nxt) y_min_nxt = y_cnt;
            if (y_cnt > y_max_nxt) y_max_nxt = y_cnt;
            if (cnt_nxt != CNT_MAX) cnt_nxt = cnt_nxt + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x_min <= X_LAST;
            acc_x_max <= '0;
            acc_y_min <= Y_LAST;
            acc_y_max <= '0;
            acc_cnt   <= '0;
        end else begin
            acc_x_min <= x_min_nxt;
            acc_x_max <= x_max_nxt;
            acc_y_min <= y_min_nxt;
            acc_y_max <= y_max_nxt;
            acc_cnt   <= cnt_nxt;
        end
    end

    assign acc_found = (acc_cnt >= MIN_CNT);

    // Result registers only move in PUBLISH, which sits inside vsync, so
    // the overlay never mixes two boxes within one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_box_valid <= 1'b0;
            o_found     <= 1'b0;
            o_x_min     <= '0;
            o_x_max     <= '0;
            o_y_min     <= '0;
            o_y_max     <= '0;
            o_pix_cnt   <= '0;
        end else begin
            o_box_valid <= publish;
            if (publish) begin
                o_found   <= acc_found;
                o_x_min   <= acc_found ? acc_x_min : 11'd0;
                o_x_max   <= acc_found ? acc_x_max : 11'd0;
                o_y_min   <= acc_found ? acc_y_min : 10'd0;
                o_y_max   <= acc_found ? acc_y_max : 10'd0;
                o_pix_cnt <= acc_cnt;
            end
        end
    end

    assign on_vline = ((x_cnt == o_x_min) || (x_cnt == o_x_max))
                    && (y_cnt >= o_y_min) && (y_cnt <= o_y_max);
    assign on_hline = ((y_cnt == o_y_min) || (y_cnt == o_y_max))
                    && (x_cnt >= o_x_min) && (x_cnt <= o_x_max);
    assign draw     = o_found & bin.href & bin.clken & in_range
                    & (on_vline | on_hline);

    // Output stage: syncs and data share the same single register delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovl.vsync <= 1'b0;
            ovl.href  <= 1'b0;
            ovl.clken <= 1'b0;
            ovl.data  <= 8'h00;
        end else begin
            ovl.vsync <= bin.vsync;
            ovl.href  <= bin.href;
            ovl.clken <= bin.clken;
            ovl.data  <= draw ? BOX_VAL : bin.data;
        end
    end

endmodule
